// File: rtl/uart_pkg.sv
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: parity encodings, transmitter FSM
//                state encoding and a frame-length helper.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  // Parity selection encodings
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // FSM state width and encodings; the state names the bit driven on the next edge
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_PAR  = 2'd2,
    ST_STOP = 2'd3
  } tx_state_t;

  // Number of line bits in one frame: start + data + optional parity + stop
  function automatic int frame_len(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_byte_fifo.sv
// ============================================================================
//  Module      : uart_byte_fifo
//  Description : Synchronous FIFO with push/pop, full/empty flags and an
//                occupancy count. Pointers wrap modulo DEPTH (power of 2).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int             AW      = $clog2(DEPTH);
  localparam logic [AW:0]    C_DEPTH = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  // A push while full or a pop while empty is dropped
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == C_DEPTH);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rptr];

  // Storage array; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : UART transmitter with a byte FIFO. Sends start, LSB-first
//                data, optional parity and stop bits, one bit per baud edge,
//                back-to-back while bytes are queued.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                          baud,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int             BCW         = $clog2(DATA_BITS);
  localparam logic [BCW-1:0] C_LAST_BIT  = BCW'(DATA_BITS - 1);
  localparam logic           C_LAST_STOP = 1'(STOP_BITS - 1);

  tx_state_t            r_state, w_state_nxt;
  logic                 r_tx, w_tx_nxt;
  logic [DATA_BITS-1:0] r_shreg, w_shreg_nxt;
  logic                 r_par, w_par_nxt;
  logic [BCW-1:0]       r_bitcnt, w_bitcnt_nxt;
  logic                 r_stopcnt, w_stopcnt_nxt;

  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [DATA_BITS-1:0] w_head;

  // Ready is withheld during reset and is not relieved by a same-edge pop
  assign wr_ready = !w_full && !rst;
  assign tx       = r_tx;
  assign busy     = (r_state != ST_IDLE) || !w_empty;

  uart_byte_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (baud),
    .rst     (rst),
    .i_push  (wr_valid && wr_ready),
    .i_data  (wr_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (count)
  );

  // State, line and datapath registers; reset aborts any frame and idles the line
  always_ff @(posedge baud) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_tx      <= 1'b1;
      r_shreg   <= '0;
      r_par     <= 1'b0;
      r_bitcnt  <= '0;
      r_stopcnt <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tx      <= w_tx_nxt;
      r_shreg   <= w_shreg_nxt;
      r_par     <= w_par_nxt;
      r_bitcnt  <= w_bitcnt_nxt;
      r_stopcnt <= w_stopcnt_nxt;
    end
  end

  // Next-state and next line bit; IDLE pops the head and launches the start bit
  always_comb begin
    w_state_nxt   = r_state;
    w_tx_nxt      = r_tx;
    w_shreg_nxt   = r_shreg;
    w_par_nxt     = r_par;
    w_bitcnt_nxt  = r_bitcnt;
    w_stopcnt_nxt = r_stopcnt;
    w_pop         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_tx_nxt     = 1'b0;
          w_shreg_nxt  = w_head;
          w_par_nxt    = (PARITY == PARITY_ODD) ? ~^w_head : ^w_head;
          w_bitcnt_nxt = '0;
          w_state_nxt  = ST_DATA;
        end else begin
          w_tx_nxt = 1'b1;
        end
      end
      ST_DATA: begin
        w_tx_nxt     = r_shreg[0];
        w_shreg_nxt  = r_shreg >> 1;
        w_bitcnt_nxt = r_bitcnt + 1'b1;
        if (r_bitcnt == C_LAST_BIT) begin
          w_stopcnt_nxt = 1'b0;
          w_state_nxt   = (PARITY != PARITY_NONE) ? ST_PAR : ST_STOP;
        end
      end
      ST_PAR: begin
        w_tx_nxt      = r_par;
        w_stopcnt_nxt = 1'b0;
        w_state_nxt   = ST_STOP;
      end
      ST_STOP: begin
        w_tx_nxt      = 1'b1;
        w_stopcnt_nxt = r_stopcnt + 1'b1;
        if (r_stopcnt == C_LAST_STOP) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_tx_nxt    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
//  Module      : tb_uart_tx_fifo
//  Description : Directed bench for uart_tx_fifo. Four instances cover the
//                parity and stop-bit variants; expected line bits are queued
//                per instance and compared after every baud edge.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;

  logic       baud;
  logic       rst;
  logic [7:0] wd0, wd1, wd2, wd3;
  logic       wv0, wv1, wv2, wv3;
  logic       rdy0, rdy1, rdy2, rdy3;
  logic       tx0, tx1, tx2, tx3;
  logic       bsy0, bsy1, bsy2, bsy3;
  logic [2:0] cnt0, cnt1, cnt2, cnt3;

  int errors = 0;
  int checks = 0;

  logic q0[$];
  logic q1[$];
  logic q2[$];
  logic q3[$];

  uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(1)) u0 (
    .baud(baud), .rst(rst), .wr_data(wd0), .wr_valid(wv0), .wr_ready(rdy0),
    .tx(tx0), .busy(bsy0), .count(cnt0));
  uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4), .PARITY(1), .STOP_BITS(1)) u1 (
    .baud(baud), .rst(rst), .wr_data(wd1), .wr_valid(wv1), .wr_ready(rdy1),
    .tx(tx1), .busy(bsy1), .count(cnt1));
  uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4), .PARITY(2), .STOP_BITS(1)) u2 (
    .baud(baud), .rst(rst), .wr_data(wd2), .wr_valid(wv2), .wr_ready(rdy2),
    .tx(tx2), .busy(bsy2), .count(cnt2));
  uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(2)) u3 (
    .baud(baud), .rst(rst), .wr_data(wd3), .wr_valid(wv3), .wr_ready(rdy3),
    .tx(tx3), .busy(bsy3), .count(cnt3));

  initial baud = 1'b0;
  always #5 baud = ~baud;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Append n line bits, written first-bit-leftmost
  task automatic add(input int u, input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      case (u)
        0: q0.push_back(bits[i]);
        1: q1.push_back(bits[i]);
        2: q2.push_back(bits[i]);
        default: q3.push_back(bits[i]);
      endcase
    end
  endtask

  // 8N1 frame of byte b, first line bit leftmost
  function automatic logic [15:0] frame8n1(input logic [7:0] b);
    logic [15:0] v;
    v = 16'h0;
    v[9] = 1'b0;
    for (int k = 0; k < 8; k++) v[8-k] = b[k];
    v[0] = 1'b1;
    return v;
  endfunction

  // One baud edge; sample 1 time unit later and compare pending line bits
  task automatic tick();
    logic e;
    @(posedge baud);
    #1;
    if (q0.size() != 0) begin e = q0.pop_front(); chk("tx_u0", {31'd0, tx0}, {31'd0, e}); end
    if (q1.size() != 0) begin e = q1.pop_front(); chk("tx_u1", {31'd0, tx1}, {31'd0, e}); end
    if (q2.size() != 0) begin e = q2.pop_front(); chk("tx_u2", {31'd0, tx2}, {31'd0, e}); end
    if (q3.size() != 0) begin e = q3.pop_front(); chk("tx_u3", {31'd0, tx3}, {31'd0, e}); end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() + q1.size() + q2.size() + q3.size()) != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain_bound", {31'd0, (n < 200)}, 32'd1);
  endtask

  logic [7:0] bytes [6];

  initial begin
    rst = 1'b1;
    wd0 = 8'h00; wd1 = 8'h00; wd2 = 8'h00; wd3 = 8'h00;
    wv0 = 1'b0;  wv1 = 1'b0;  wv2 = 1'b0;  wv3 = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_tx",    {31'd0, tx0},  32'd1);
    chk("rst_busy",  {31'd0, bsy0}, 32'd0);
    chk("rst_count", {29'd0, cnt0}, 32'd0);
    chk("rst_ready", {31'd0, rdy0}, 32'd0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", {31'd0, rdy0}, 32'd1);
    chk("idle_tx",         {31'd0, tx0},  32'd1);

    // 8N1 frame of 0xA5
    wv0 = 1'b1; wd0 = 8'hA5;
    tick();
    wv0 = 1'b0;
    chk("t1_count", {29'd0, cnt0}, 32'd1);
    chk("t1_busy",  {31'd0, bsy0}, 32'd1);
    add(0, 16'b0101001011, 10);
    drain();
    chk("t1_busy_low", {31'd0, bsy0}, 32'd0);

    // Even parity 0xA5 (parity 0) and odd parity 0x07 (parity 0)
    wv1 = 1'b1; wd1 = 8'hA5;
    wv2 = 1'b1; wd2 = 8'h07;
    tick();
    wv1 = 1'b0; wv2 = 1'b0;
    add(1, 16'b01010010101, 11);
    add(2, 16'b01110000001, 11);
    drain();
    chk("t2_busy1", {31'd0, bsy1}, 32'd0);
    chk("t2_busy2", {31'd0, bsy2}, 32'd0);

    // Two stop bits: 0x00 then 0xFF back to back
    wv3 = 1'b1; wd3 = 8'h00;
    tick();
    add(3, 16'b00000000011, 11);
    add(3, 16'b01111111111, 11);
    wd3 = 8'hFF;
    tick();
    wv3 = 1'b0;
    drain();
    chk("t4_busy", {31'd0, bsy3}, 32'd0);

    // Fill the FIFO, hold a further byte with changing data while full
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
    bytes[3] = 8'h44; bytes[4] = 8'h55; bytes[5] = 8'h5A;
    wv0 = 1'b1; wd0 = bytes[0];
    tick();
    for (int i = 0; i < 6; i++) add(0, frame8n1(bytes[i]), 10);
    chk("t3_cnt0", {29'd0, cnt0}, 32'd1);
    wd0 = bytes[1]; tick(); chk("t3_cnt1", {29'd0, cnt0}, 32'd1);
    wd0 = bytes[2]; tick(); chk("t3_cnt2", {29'd0, cnt0}, 32'd2);
    wd0 = bytes[3]; tick(); chk("t3_cnt3", {29'd0, cnt0}, 32'd3);
    wd0 = bytes[4]; tick(); chk("t3_cnt4", {29'd0, cnt0}, 32'd4);
    chk("t3_full_ready", {31'd0, rdy0}, 32'd0);
    for (int i = 0; i < 7; i++) begin
      wd0 = 8'($urandom_range(255, 0));
      tick();
      chk("t3_held_ready", {31'd0, rdy0}, {31'd0, (i == 6)});
    end
    wd0 = bytes[5];
    tick();
    wv0 = 1'b0;
    chk("t3_cnt_refill", {29'd0, cnt0}, 32'd4);
    drain();
    chk("t3_busy_low", {31'd0, bsy0}, 32'd0);

    // Reset during data bit 3 of 0x3C with two bytes still queued
    wv0 = 1'b1; wd0 = 8'h3C;
    tick();
    add(0, 16'b0001, 4);
    wd0 = 8'h77; tick();
    wd0 = 8'h88; tick();
    wv0 = 1'b0;
    tick();
    chk("t5_cnt_before", {29'd0, cnt0}, 32'd2);
    rst = 1'b1;
    tick();
    chk("t5_tx",    {31'd0, tx0},  32'd1);
    chk("t5_count", {29'd0, cnt0}, 32'd0);
    chk("t5_busy",  {31'd0, bsy0}, 32'd0);
    chk("t5_ready", {31'd0, rdy0}, 32'd0);
    rst = 1'b0;
    add(0, 16'hFFFF, 15);
    drain();
    chk("t5_quiet_count", {29'd0, cnt0}, 32'd0);
    chk("t5_quiet_busy",  {31'd0, bsy0}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
